// File: rtl/vliw_issue_ctrl.sv
// VLIW issue controller: holds one bundle and hands each non-NOP lane to its core.
// Latency 1 cycle from accept to core_valid; a new bundle is taken only once every pending lane is handshaking.
module vliw_issue_ctrl #(
  parameter int CORES    = 4,
  parameter int INST_LEN = 32
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  input  logic [CORES*INST_LEN-1:0] bundle,
  input  logic                      bundle_valid,
  output logic                      bundle_ready,
  output logic [CORES*INST_LEN-1:0] core_inst,
  output logic [CORES-1:0]          core_valid,
  input  logic [CORES-1:0]          core_ready,
  output logic [15:0]               issue_count,
  output logic                      busy
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                    state, state_nxt;
  logic [CORES-1:0]          pending, pending_nxt;
  logic [CORES-1:0]          remaining;
  logic [CORES-1:0]          new_mask;
  logic [CORES*INST_LEN-1:0] inst_nxt;
  logic [15:0]               count_nxt;
  logic                      accept;
  logic                      done_old;
  logic                      done_new;

  // Lane 0 sits in the most-significant slice of the bundle.
  always_comb begin
    new_mask = '0;
    for (int i = 0; i < CORES; i++) begin
      new_mask[i] = |bundle[(CORES-1-i)*INST_LEN +: INST_LEN];
    end
  end

  assign remaining    = pending & ~core_ready;
  assign bundle_ready = reset_n && !flush && ((state == IDLE) || (remaining == '0));
  assign accept       = bundle_valid && bundle_ready;
  assign done_old     = !flush && (state == ISSUE) && (remaining == '0);
  // An all-NOP bundle completes the moment it is accepted.
  assign done_new     = accept && (new_mask == '0);

  always_comb begin
    state_nxt   = state;
    pending_nxt = pending;
    inst_nxt    = core_inst;
    count_nxt   = issue_count + 16'(done_old) + 16'(done_new);
    if (flush) begin
      state_nxt   = IDLE;
      pending_nxt = '0;
    end else if (accept) begin
      inst_nxt    = bundle;
      pending_nxt = new_mask;
      state_nxt   = (new_mask != '0) ? ISSUE : IDLE;
    end else if (state == ISSUE) begin
      pending_nxt = remaining;
      if (remaining == '0) begin
        state_nxt = IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      pending     <= '0;
      core_inst   <= '0;
      issue_count <= '0;
    end else begin
      state       <= state_nxt;
      pending     <= pending_nxt;
      core_inst   <= inst_nxt;
      issue_count <= count_nxt;
    end
  end

  assign core_valid = pending;
  assign busy       = (state == ISSUE);

endmodule

// File: tb/tb_vliw_issue_ctrl.sv
// Directed bench for vliw_issue_ctrl: per-lane expected-instruction queues checked by a handshake monitor,
// plus cycle-accurate checks of valid/ready/busy/count from the stimulus thread.
module tb_vliw_issue_ctrl;
  localparam int CORES = 4;
  localparam int IL    = 32;

  logic                   clk = 1'b0;
  logic                   reset_n;
  logic                   flush;
  logic [CORES*IL-1:0]    bundle;
  logic                   bundle_valid;
  logic                   bundle_ready;
  logic [CORES*IL-1:0]    core_inst;
  logic [CORES-1:0]       core_valid;
  logic [CORES-1:0]       core_ready;
  logic [15:0]            issue_count;
  logic                   busy;

  int checks   = 0;
  int failures = 0;
  logic [IL-1:0] exp_q [CORES][$];

  vliw_issue_ctrl #(.CORES(CORES), .INST_LEN(IL)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .bundle(bundle),
    .bundle_valid(bundle_valid), .bundle_ready(bundle_ready),
    .core_inst(core_inst), .core_valid(core_valid), .core_ready(core_ready),
    .issue_count(issue_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [IL-1:0] lane(input int i);
    return core_inst[(CORES-1-i)*IL +: IL];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Queue the non-NOP lanes of a bundle that is expected to be issued.
  task automatic expect_bundle(input logic [CORES*IL-1:0] b);
    for (int i = 0; i < CORES; i++) begin
      if (b[(CORES-1-i)*IL +: IL] != '0) exp_q[i].push_back(b[(CORES-1-i)*IL +: IL]);
    end
  endtask

  task automatic drop_all();
    for (int i = 0; i < CORES; i++) exp_q[i].delete();
  endtask

  // Monitor: every live lane handshake must deliver the next queued instruction for that lane.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && !flush) begin
        for (int i = 0; i < CORES; i++) begin
          if (core_valid[i] && core_ready[i]) begin
            if (exp_q[i].size() == 0) begin
              checks++;
              failures++;
              $display("FAIL unexpected_issue lane%0d: got %0h expected none", i, lane(i));
            end else begin
              chk($sformatf("lane%0d_inst", i), lane(i), exp_q[i].pop_front());
            end
          end
        end
      end
    end
  end

  localparam logic [127:0] B1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] B2 = 128'h55555555_66666666_77777777_88888888;
  localparam logic [127:0] B3 = 128'h00000000_00000000_00000000_0000ABCD;
  localparam logic [127:0] BA = 128'hA0000001_A0000002_A0000003_A0000004;
  localparam logic [127:0] BB = 128'hB0000001_B0000002_B0000003_B0000004;
  localparam logic [127:0] BC = 128'hC0000001_C0000002_C0000003_C0000004;
  localparam logic [127:0] BF = 128'h00000000_AAAA0001_BBBB0002_00000000;
  localparam logic [127:0] BD = 128'hD0000001_D0000002_D0000003_D0000004;

  initial begin
    logic [3:0] stag [4];
    logic [3:0] stag_cv [4];
    reset_n = 1'b0; flush = 1'b0; bundle = '0; bundle_valid = 1'b0; core_ready = '0;
    step(); step();
    chk("rst_br_low", bundle_ready, 1'b0);
    reset_n = 1'b1;
    #1;
    chk("rst_core_valid", core_valid, 4'b0000);
    chk("rst_busy", busy, 1'b0);
    chk("rst_count", issue_count, 16'd0);
    chk("rst_core_inst", core_inst, 128'h0);
    chk("idle_br", bundle_ready, 1'b1);

    // Basic issue, all cores ready.
    bundle = B1; bundle_valid = 1'b1; core_ready = 4'b1111; expect_bundle(B1);
    step();
    bundle_valid = 1'b0;
    chk("basic_cv", core_valid, 4'b1111);
    chk("basic_lane0", lane(0), 32'h11111111);
    chk("basic_busy", busy, 1'b1);
    step();
    chk("basic_cv_done", core_valid, 4'b0000);
    chk("basic_count", issue_count, 16'd1);

    // Staggered ready; already-issued lanes keep their ready bit high to show it is ignored.
    bundle = B2; bundle_valid = 1'b1; core_ready = 4'b0000; expect_bundle(B2);
    step();
    bundle_valid = 1'b0;
    stag    = '{4'b1000, 4'b1100, 4'b1110, 4'b1111};
    stag_cv = '{4'b1111, 4'b0111, 4'b0011, 4'b0001};
    for (int c = 0; c < 4; c++) begin
      core_ready = stag[c];
      #1;
      chk($sformatf("stag_cv_c%0d", c + 1), core_valid, stag_cv[c]);
      chk($sformatf("stag_br_c%0d", c + 1), bundle_ready, (c == 3));
      step();
    end
    chk("stag_cv_end", core_valid, 4'b0000);
    chk("stag_count", issue_count, 16'd2);

    // ABCD is in the least-significant slice, i.e. lane 3 -> core_valid bit 3.
    bundle = B3; bundle_valid = 1'b1; core_ready = 4'b0000; expect_bundle(B3);
    step();
    bundle_valid = 1'b0;
    chk("nop_cv", core_valid, 4'b1000);
    core_ready = 4'b1111;
    step();
    chk("nop_count", issue_count, 16'd3);
    bundle = '0; bundle_valid = 1'b1;
    step();
    bundle_valid = 1'b0;
    chk("allnop_count", issue_count, 16'd4);
    chk("allnop_busy", busy, 1'b0);
    chk("allnop_cv", core_valid, 4'b0000);

    // Back-to-back: three bundles, valid held, no bubble.
    bundle = BA; bundle_valid = 1'b1; expect_bundle(BA);
    step();
    chk("b2b_lane0_a", lane(0), BA[127:96]);
    chk("b2b_br_a", bundle_ready, 1'b1);
    bundle = BB; expect_bundle(BB);
    step();
    chk("b2b_lane0_b", lane(0), BB[127:96]);
    chk("b2b_count_b", issue_count, 16'd5);
    bundle = BC; expect_bundle(BC);
    step();
    chk("b2b_lane0_c", lane(0), BC[127:96]);
    chk("b2b_count_c", issue_count, 16'd6);
    chk("b2b_cv_c", core_valid, 4'b1111);
    bundle_valid = 1'b0;
    step();
    chk("b2b_count_end", issue_count, 16'd7);
    chk("b2b_busy_end", busy, 1'b0);

    // Flush with lanes 1 and 2 pending; the same-cycle handshakes are discarded.
    bundle = BF; bundle_valid = 1'b1; core_ready = 4'b0000;
    step();
    bundle_valid = 1'b0;
    chk("flush_pre_cv", core_valid, 4'b0110);
    flush = 1'b1; core_ready = 4'b1111;
    #1;
    chk("flush_br", bundle_ready, 1'b0);
    step();
    flush = 1'b0;
    chk("flush_cv", core_valid, 4'b0000);
    chk("flush_busy", busy, 1'b0);
    chk("flush_count", issue_count, 16'd7);

    // Completion coinciding with accept of an all-NOP bundle counts both.
    bundle = BD; bundle_valid = 1'b1; expect_bundle(BD);
    step();
    bundle = '0;
    step();
    bundle_valid = 1'b0;
    chk("done_nop_count", issue_count, 16'd9);
    chk("done_nop_busy", busy, 1'b0);

    // Drive the counter to FFFF with NOP bundles, then wrap it with a real bundle.
    bundle = '0; bundle_valid = 1'b1;
    repeat (65535 - 9) step();
    chk("pre_wrap_count", issue_count, 16'hFFFF);
    bundle = B1; expect_bundle(B1);
    step();
    bundle_valid = 1'b0;
    step();
    chk("wrap_count", issue_count, 16'h0000);

    // Reset while a bundle is held.
    bundle = B2; bundle_valid = 1'b1; core_ready = 4'b0000;
    step();
    bundle_valid = 1'b0;
    chk("mid_busy", busy, 1'b1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_br", bundle_ready, 1'b0);
    step();
    drop_all();
    chk("mid_rst_cv", core_valid, 4'b0000);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_count", issue_count, 16'd0);
    chk("mid_rst_inst", core_inst, 128'h0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_br", bundle_ready, 1'b1);

    step();
    for (int i = 0; i < CORES; i++) begin
      chk($sformatf("leftover_lane%0d", i), exp_q[i].size(), 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
